// File: rtl/mod12_pkg.sv
// Shared types and defaults for the modulo-12 count controller and its prescaler.
package mod12_pkg;

    localparam int DEFAULT_MODULUS  = 12;
    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_op_t;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        cnt_width = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod12_prescaler.sv
// Tick divider: emits a same-cycle step for every PRESCALE enabled ticks.
module mod12_prescaler
    import mod12_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int CW = cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] pcnt_r;
    logic          at_last_s;
    logic          step_s;

    // Terminal-count decode; the step must coincide with the tick that completes it.
    always_comb begin
        at_last_s = 1'b0;
        step_s    = 1'b0;
        if (pcnt_r >= LAST) begin
            at_last_s = 1'b1;
        end else begin
            at_last_s = 1'b0;
        end
        if (enable && tick && !clear) begin
            step_s = at_last_s;
        end else begin
            step_s = 1'b0;
        end
    end

    assign step = step_s;

    // Prescale counter: clear has priority, holds whenever not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= {CW{1'b0}};
        end else if (clear) begin
            pcnt_r <= {CW{1'b0}};
        end else if (enable && tick) begin
            if (at_last_s) begin
                pcnt_r <= {CW{1'b0}};
            end else begin
                pcnt_r <= pcnt_r + ONE;
            end
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

endmodule

// File: rtl/mod12_counter_ctrl.sv
// Run controller for the modulo-MODULUS counter: command FSM, count register, wrap/err pulses.
module mod12_counter_ctrl
    import mod12_pkg::*;
#(
    parameter int MODULUS  = DEFAULT_MODULUS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             tick,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             running,
    output logic             err
);

    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             err_r;
    logic             running_r;
    logic             cmd_ready_r;

    cmd_op_t          op_s;
    logic             accept_s;
    logic             start_s;
    logic             stop_s;
    logic             clear_s;
    logic             load_ok_s;
    logic             load_bad_s;
    logic             pcnt_clear_s;
    logic             pcnt_en_s;
    logic             step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             wrap_step_s;

    // Command decode and next-count arithmetic with explicit boundary compares.
    always_comb begin
        op_s         = cmd_op_t'(cmd_op);
        accept_s     = cmd_valid && cmd_ready_r;
        start_s      = 1'b0;
        stop_s       = 1'b0;
        clear_s      = 1'b0;
        load_ok_s    = 1'b0;
        load_bad_s   = 1'b0;
        q_step_s     = q_r;
        wrap_step_s  = 1'b0;
        if (accept_s) begin
            case (op_s)
                CMD_START: start_s = 1'b1;
                CMD_STOP:  stop_s  = 1'b1;
                CMD_CLEAR: clear_s = 1'b1;
                CMD_LOAD: begin
                    if ({1'b0, cmd_data} < MOD_EXT) begin
                        load_ok_s = 1'b1;
                    end else begin
                        load_bad_s = 1'b1;
                    end
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end

        if (up_dn) begin
            if (q_r >= Q_MAX) begin
                q_step_s    = Q_ZERO;
                wrap_step_s = 1'b1;
            end else begin
                q_step_s    = q_r + Q_ONE;
                wrap_step_s = 1'b0;
            end
        end else begin
            if (q_r == Q_ZERO) begin
                q_step_s    = Q_MAX;
                wrap_step_s = 1'b1;
            end else begin
                q_step_s    = q_r - Q_ONE;
                wrap_step_s = 1'b0;
            end
        end
    end

    // LOAD/CLEAR (even a rejected LOAD) steal the cycle's tick; START only clears when it actually starts.
    always_comb begin
        pcnt_clear_s = clear_s || load_ok_s || (start_s && (state_r != RUN));
        if ((state_r == RUN) && !clear_s && !load_ok_s && !load_bad_s) begin
            pcnt_en_s = 1'b1;
        end else begin
            pcnt_en_s = 1'b0;
        end
    end

    mod12_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .tick   (tick),
        .clear  (pcnt_clear_s),
        .enable (pcnt_en_s),
        .step   (step_s)
    );

    // Run-state FSM with the count register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            q_r         <= Q_ZERO;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            running_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            cmd_ready_r <= 1'b1;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;

            if (load_bad_s) begin
                err_r <= 1'b1;
                q_r   <= q_r;
            end else if (load_ok_s) begin
                q_r <= cmd_data;
            end else if (clear_s) begin
                q_r <= Q_ZERO;
            end else if (step_s) begin
                q_r    <= q_step_s;
                wrap_r <= wrap_step_s;
            end else begin
                q_r <= q_r;
            end

            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop_s) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end else if (clear_s) begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else if (clear_s) begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_r;
    assign wrap      = wrap_r;
    assign err       = err_r;
    assign running   = running_r;
    assign cmd_ready = cmd_ready_r;

endmodule
